// File: rtl/up_axi_master_pkg.sv
// -----------------------------------------------------------------------------
// up_axi_master_pkg
// Shared constants for the up_* to AXI4-Lite master bridge:
//   - AXI response codes (OKAY / SLVERR / DECERR)
//   - the read-data pattern returned when a read is forced to finish by timeout
//   - resp_is_err(): maps an AXI response onto the up_err flag
// -----------------------------------------------------------------------------
package up_axi_master_pkg;

   localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;

   localparam logic [31:0] TIMEOUT_RDATA   = 32'hdead_dead;

   // Both error codes have bit 1 set; EXOKAY (2'b01) is not an error.
   function automatic logic resp_is_err(input logic [1:0] resp);
      logic err;
      case (resp)
         AXI_RESP_SLVERR, AXI_RESP_DECERR: err = 1'b1;
         default:                          err = 1'b0;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/up_axi_master.sv
// -----------------------------------------------------------------------------
// up_axi_master
// Turns up_* register-bus requests into AXI4-Lite master transactions, one
// transaction outstanding, with a per-transaction timeout.
//
// Ports
//   up_clk, up_rst               clock, asynchronous active-high reset
//   up_wreq/up_waddr/up_wdata    write request pulse + word address + data
//   up_wack                      write completion pulse
//   up_rreq/up_raddr             read request pulse + word address
//   up_rack/up_rdata             read completion pulse + data (0 when no rack)
//   up_busy                      a transaction is in flight
//   up_err                       with an ack: SLVERR/DECERR or timeout
//   up_ovf                       sticky: a request was dropped (reset clears)
//   m_axi_aw*/w*/b*/ar*/r*       AXI4-Lite master channels
//   dbg_state                    current FSM state (IDLE = 0)
//
// Handshakes: every AXI channel uses valid/ready; a transfer happens on the
// rising edge where both are high. A valid, once raised, stays high with
// stable payload until its transfer (or a timeout); readies are driven only in
// the state that expects the response. The up_* request pulses have no ready:
// a request arriving while busy (or a read colliding with a write) is dropped
// and flagged on up_ovf.
// -----------------------------------------------------------------------------
module up_axi_master
   import up_axi_master_pkg::*;
#(
   parameter int          ADDRESS_WIDTH = 14,
   parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
   parameter int          TIMEOUT       = 1023
) (
   input  logic                     up_clk,
   input  logic                     up_rst,
   input  logic                     up_wreq,
   input  logic [ADDRESS_WIDTH-1:0] up_waddr,
   input  logic [31:0]              up_wdata,
   output logic                     up_wack,
   input  logic                     up_rreq,
   input  logic [ADDRESS_WIDTH-1:0] up_raddr,
   output logic [31:0]              up_rdata,
   output logic                     up_rack,
   output logic                     up_busy,
   output logic                     up_err,
   output logic                     up_ovf,
   output logic                     m_axi_awvalid,
   output logic [31:0]              m_axi_awaddr,
   output logic [2:0]               m_axi_awprot,
   input  logic                     m_axi_awready,
   output logic                     m_axi_wvalid,
   output logic [31:0]              m_axi_wdata,
   output logic [3:0]               m_axi_wstrb,
   input  logic                     m_axi_wready,
   input  logic                     m_axi_bvalid,
   input  logic [1:0]               m_axi_bresp,
   output logic                     m_axi_bready,
   output logic                     m_axi_arvalid,
   output logic [31:0]              m_axi_araddr,
   output logic [2:0]               m_axi_arprot,
   input  logic                     m_axi_arready,
   input  logic                     m_axi_rvalid,
   input  logic [31:0]              m_axi_rdata,
   input  logic [1:0]               m_axi_rresp,
   output logic                     m_axi_rready,
   output logic [2:0]               dbg_state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WADDR = 3'd1;
   localparam logic [2:0] S_WRESP = 3'd2;
   localparam logic [2:0] S_RADDR = 3'd3;
   localparam logic [2:0] S_RDATA = 3'd4;

   localparam int             TW       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   // The ack is registered, so the forced completion is decided one cycle
   // before the counter would read TIMEOUT.
   localparam logic [TW-1:0]  CNT_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]  CNT_MAX  = TW'(TIMEOUT);

   logic [2:0]    state_q, state_d;
   logic [TW-1:0] cnt_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;
   logic [31:0]   waddr_byte, raddr_byte;
   logic          to_hit;
   logic          wr_fin, rd_fin;
   logic          err_d;
   logic [31:0]   rdata_d;

   assign waddr_byte = BASE_ADDR | (32'(up_waddr) << 2);
   assign raddr_byte = BASE_ADDR | (32'(up_raddr) << 2);

   // Saturating compare: a transition that lands on the last cycle still
   // leaves the counter above CNT_LAST, so the next state times out at once.
   assign to_hit = (state_q != S_IDLE) && (cnt_q >= CNT_LAST);

   // State register
   always_ff @(posedge up_clk or posedge up_rst) begin
      if (up_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE)
            cnt_q <= '0;
         else if (cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   // Next-state logic; a real handshake takes precedence over the timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (up_wreq)
               state_d = S_WADDR;
            else if (up_rreq)
               state_d = S_RADDR;
         end
         S_WADDR: begin
            if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready))
               state_d = S_WRESP;
            else if (to_hit)
               state_d = S_IDLE;
         end
         S_WRESP: begin
            if (m_axi_bvalid || to_hit)
               state_d = S_IDLE;
         end
         S_RADDR: begin
            if (m_axi_arready)
               state_d = S_RDATA;
            else if (to_hit)
               state_d = S_IDLE;
         end
         S_RDATA: begin
            if (m_axi_rvalid || to_hit)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: readies/busy straight from state, completion values that
   // feed the registered up_* outputs.
   always_comb begin
      m_axi_bready = (state_q == S_WRESP);
      m_axi_rready = (state_q == S_RDATA);
      up_busy      = (state_q != S_IDLE);
      dbg_state    = state_q;
      wr_fin       = ((state_q == S_WADDR) || (state_q == S_WRESP)) && (state_d == S_IDLE);
      rd_fin       = ((state_q == S_RADDR) || (state_q == S_RDATA)) && (state_d == S_IDLE);
      err_d        = 1'b0;
      rdata_d      = '0;
      if ((state_q == S_WRESP) && m_axi_bvalid) begin
         err_d = resp_is_err(m_axi_bresp);
      end else if ((state_q == S_RDATA) && m_axi_rvalid) begin
         err_d   = resp_is_err(m_axi_rresp);
         rdata_d = m_axi_rdata;
      end else if (wr_fin || rd_fin) begin
         err_d = 1'b1;
         if (rd_fin)
            rdata_d = TIMEOUT_RDATA;
      end
   end

   // Registered datapath: valids, payload and up_* completion outputs.
   always_ff @(posedge up_clk or posedge up_rst) begin
      if (up_rst) begin
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         up_wack       <= 1'b0;
         up_rack       <= 1'b0;
         up_err        <= 1'b0;
         up_rdata      <= '0;
         up_ovf        <= 1'b0;
      end else begin
         up_wack  <= wr_fin;
         up_rack  <= rd_fin;
         up_err   <= err_d;
         up_rdata <= rdata_d;

         if (state_q == S_IDLE) begin
            m_axi_awvalid <= up_wreq;
            m_axi_wvalid  <= up_wreq;
            m_axi_arvalid <= up_rreq && !up_wreq;
            if (up_wreq) begin
               addr_q  <= waddr_byte;
               wdata_q <= up_wdata;
               wstrb_q <= 4'hf;
            end else if (up_rreq) begin
               addr_q  <= raddr_byte;
            end
            if (up_wreq && up_rreq)
               up_ovf <= 1'b1;
         end else begin
            if (m_axi_awready || (state_d == S_IDLE))
               m_axi_awvalid <= 1'b0;
            if (m_axi_wready || (state_d == S_IDLE))
               m_axi_wvalid  <= 1'b0;
            if (m_axi_arready || (state_d == S_IDLE))
               m_axi_arvalid <= 1'b0;
            if (up_wreq || up_rreq)
               up_ovf <= 1'b1;
         end
      end
   end

   assign m_axi_awaddr = addr_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign m_axi_wdata  = wdata_q;
   assign m_axi_wstrb  = wstrb_q;

endmodule

// File: tb/tb_up_axi_master.sv
// -----------------------------------------------------------------------------
// tb_up_axi_master
// Self-checking bench for up_axi_master (TIMEOUT = 15). A configurable AXI4-Lite
// slave responds on the falling edge; expected completions are queued when a
// request is driven and compared when up_wack/up_rack appears.
// -----------------------------------------------------------------------------
module tb_up_axi_master;
   import up_axi_master_pkg::*;

   localparam int AW = 14;
   localparam int TO = 15;

   logic          up_clk = 1'b0;
   logic          up_rst;
   logic          up_wreq, up_rreq;
   logic [AW-1:0] up_waddr, up_raddr;
   logic [31:0]   up_wdata, up_rdata;
   logic          up_wack, up_rack, up_busy, up_err, up_ovf;
   logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [31:0]   m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
   logic [2:0]    m_axi_awprot, m_axi_arprot, dbg_state;
   logic [3:0]    m_axi_wstrb;
   logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic [1:0]    m_axi_bresp, m_axi_rresp;
   logic          m_axi_rvalid, m_axi_rready;

   up_axi_master #(.ADDRESS_WIDTH(AW), .BASE_ADDR(32'h0), .TIMEOUT(TO)) dut (
      .up_clk(up_clk), .up_rst(up_rst),
      .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
      .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
      .up_busy(up_busy), .up_err(up_err), .up_ovf(up_ovf),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awready(m_axi_awready),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wready(m_axi_wready),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arready(m_axi_arready),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rready(m_axi_rready),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 up_clk = ~up_clk;

   int cyc = 0;
   always @(posedge up_clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- slave configuration ----------------
   int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
   bit          b_never = 1'b0, r_never = 1'b0;
   logic [1:0]  bresp_cfg = AXI_RESP_OKAY, rresp_cfg = AXI_RESP_OKAY;
   logic [31:0] rdata_cfg = '0;
   int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;

   // ---------------- monitor state / scoreboard ----------------
   logic [33:0] exp_q[$];   // {is_read, err, rdata}
   logic [33:0] e;
   int          last_ack_cyc = 0, ack_count = 0, ar_rise = 0;
   int          hold_viol = 0, bready_early = 0, rdata_nz = 0;
   int          w_fall = -1, aw_fall = -1;
   logic [4:0]  ack_valids = '0;
   logic [31:0] seen_awaddr = '0, seen_wdata = '0, seen_araddr = '0;
   logic [3:0]  seen_wstrb = '0;
   logic [2:0]  seen_prot = '0;
   logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
   logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;

   always @(negedge up_clk) begin
      // protocol watch: valid held with stable payload until its handshake
      if (!up_rst && !(up_wack || up_rack)) begin
         if (p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr)) hold_viol++;
         if (p_wv  && !p_wr  && (!m_axi_wvalid  || m_axi_wdata  !== p_wdata))  hold_viol++;
         if (p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr !== p_araddr)) hold_viol++;
      end
      if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) bready_early++;
      if (!up_rack && up_rdata !== 32'h0) rdata_nz++;
      if (m_axi_arvalid && !p_arv) ar_rise++;
      if (m_axi_awvalid) seen_awaddr = m_axi_awaddr;
      if (m_axi_wvalid) begin
         seen_wdata = m_axi_wdata;
         seen_wstrb = m_axi_wstrb;
      end
      if (m_axi_arvalid) seen_araddr = m_axi_araddr;
      seen_prot = seen_prot | m_axi_awprot | m_axi_arprot;
      if (p_wv && !m_axi_wvalid && w_fall < 0) w_fall = cyc;
      if (p_awv && !m_axi_awvalid && aw_fall < 0) aw_fall = cyc;

      // scoreboard
      if (up_wack || up_rack) begin
         ack_count++;
         last_ack_cyc = cyc;
         ack_valids = {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready};
         if (exp_q.size() == 0) begin
            check("spurious_ack", {62'h0, up_rack, up_wack}, 64'h0);
         end else begin
            e = exp_q.pop_front();
            check("ack_kind", {62'h0, up_rack, up_wack}, e[33] ? 64'h2 : 64'h1);
            check("ack_err", {63'h0, up_err}, {63'h0, e[32]});
            if (e[33]) check("ack_rdata", {32'h0, up_rdata}, {32'h0, e[31:0]});
         end
      end

      // slave model
      if (m_axi_awvalid) begin m_axi_awready = (aw_wait >= aw_delay); aw_wait++; end
      else begin m_axi_awready = 1'b0; aw_wait = 0; end
      if (m_axi_wvalid) begin m_axi_wready = (w_wait >= w_delay); w_wait++; end
      else begin m_axi_wready = 1'b0; w_wait = 0; end
      if (m_axi_arvalid) begin m_axi_arready = (ar_wait >= ar_delay); ar_wait++; end
      else begin m_axi_arready = 1'b0; ar_wait = 0; end
      if (m_axi_bready && !b_never) begin
         m_axi_bvalid = (b_wait >= b_delay); b_wait++;
         m_axi_bresp  = m_axi_bvalid ? bresp_cfg : AXI_RESP_OKAY;
      end else begin
         m_axi_bvalid = 1'b0; b_wait = 0; m_axi_bresp = AXI_RESP_OKAY;
      end
      if (m_axi_rready && !r_never) begin
         m_axi_rvalid = (r_wait >= r_delay); r_wait++;
         m_axi_rdata  = m_axi_rvalid ? rdata_cfg : 32'h0;
         m_axi_rresp  = m_axi_rvalid ? rresp_cfg : AXI_RESP_OKAY;
      end else begin
         m_axi_rvalid = 1'b0; r_wait = 0; m_axi_rdata = 32'h0; m_axi_rresp = AXI_RESP_OKAY;
      end

      p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
      p_wv  = m_axi_wvalid;  p_wr  = m_axi_wready;  p_wdata  = m_axi_wdata;
      p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
   end

   // ---------------- driver tasks ----------------
   task automatic slave_defaults();
      aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0;
      b_never = 1'b0; r_never = 1'b0;
      bresp_cfg = AXI_RESP_OKAY; rresp_cfg = AXI_RESP_OKAY; rdata_cfg = '0;
   endtask

   task automatic do_reset();
      @(negedge up_clk); #2;
      up_rst = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge up_clk);
      #2 up_rst = 1'b0;
   endtask

   // req_cyc: index of the cycle in which the request pulse is high
   task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic exp_err,
                           input bit expect_ack, output int req_cyc);
      @(negedge up_clk); #2;
      up_wreq = 1'b1; up_waddr = a; up_wdata = d; req_cyc = cyc;
      if (expect_ack) exp_q.push_back({1'b0, exp_err, 32'h0});
      @(negedge up_clk); #2;
      up_wreq = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [31:0] exp_data, input logic exp_err,
                          output int req_cyc);
      @(negedge up_clk); #2;
      up_rreq = 1'b1; up_raddr = a; req_cyc = cyc;
      exp_q.push_back({1'b1, exp_err, exp_data});
      @(negedge up_clk); #2;
      up_rreq = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      do begin
         @(negedge up_clk); #2;
         n++;
      end while ((up_busy || exp_q.size() != 0) && n < budget);
      check(tag, {63'h0, (up_busy || exp_q.size() != 0)}, 64'h0);
   endtask

   // ---------------- test sequence ----------------
   int rc, acks_before, ar_before, n;
   logic [1:0]  rr;
   logic [31:0] rd_val;

   initial begin
      up_rst = 1'b1; up_wreq = 0; up_rreq = 0; up_waddr = '0; up_raddr = '0; up_wdata = '0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_bresp = '0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
      repeat (3) @(negedge up_clk);
      #2;
      check("rst_outputs", {63'h0, |{up_wack, up_rack, up_rdata, up_busy, up_err, up_ovf,
            m_axi_awvalid, m_axi_awaddr, m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_bready,
            m_axi_arvalid, m_axi_araddr, m_axi_rready}}, 64'h0);
      check("rst_state", {61'h0, dbg_state}, 64'h0);
      up_rst = 1'b0;

      // Basic write, always-ready slave
      do_write(14'h010, 32'h1234_5678, 1'b0, 1'b1, rc);
      wait_idle("wr_done", 20);
      check("wr_awaddr", {32'h0, seen_awaddr}, 64'h40);
      check("wr_wdata", {32'h0, seen_wdata}, 64'h1234_5678);
      check("wr_wstrb", {60'h0, seen_wstrb}, 64'hf);
      check("wr_latency", 64'(last_ack_cyc - rc), 64'd3);

      // Read with arready after 2 cycles and rvalid after 5
      ar_delay = 2; r_delay = 5; rdata_cfg = 32'hcafe_f00d;
      do_read(14'h002, 32'hcafe_f00d, 1'b0, rc);
      wait_idle("rd_done", 30);
      check("rd_araddr", {32'h0, seen_araddr}, 64'h8);
      check("rd_latency", 64'(last_ack_cyc - rc), 64'd10);
      slave_defaults();

      // wready four cycles ahead of awready
      aw_delay = 4; w_fall = -1; aw_fall = -1; acks_before = ack_count;
      do_write(14'h3ff, 32'ha5a5_5a5a, 1'b0, 1'b1, rc);
      wait_idle("split_done", 30);
      check("split_w_first", 64'(aw_fall - w_fall), 64'd4);
      check("split_latency", 64'(last_ack_cyc - rc), 64'd7);
      check("split_one_ack", 64'(ack_count - acks_before), 64'd1);
      slave_defaults();

      // Second write while busy is dropped and flagged
      aw_delay = 3; acks_before = ack_count;
      do_write(14'h020, 32'h1111_2222, 1'b0, 1'b1, rc);
      do_write(14'h021, 32'h3333_4444, 1'b0, 1'b0, n);
      wait_idle("busy_done", 30);
      repeat (6) @(negedge up_clk);
      #2;
      check("busy_ovf", {63'h0, up_ovf}, 64'h1);
      check("busy_one_ack", 64'(ack_count - acks_before), 64'd1);
      check("busy_wdata", {32'h0, seen_wdata}, 64'h1111_2222);
      slave_defaults();
      do_reset();
      check("ovf_cleared", {63'h0, up_ovf}, 64'h0);

      // Simultaneous write and read: only the write happens
      ar_before = ar_rise;
      @(negedge up_clk); #2;
      up_wreq = 1; up_rreq = 1; up_waddr = 14'h030; up_raddr = 14'h031; up_wdata = 32'h0f0f_0f0f;
      rc = cyc; exp_q.push_back({1'b0, 1'b0, 32'h0});
      @(negedge up_clk); #2;
      up_wreq = 0; up_rreq = 0;
      wait_idle("sim_done", 20);
      check("sim_ovf", {63'h0, up_ovf}, 64'h1);
      check("sim_no_read", 64'(ar_rise - ar_before), 64'd0);
      check("sim_awaddr", {32'h0, seen_awaddr}, 64'hc0);
      check("sim_latency", 64'(last_ack_cyc - rc), 64'd3);

      // Write timeout: slave never responds
      b_never = 1'b1;
      do_write(14'h005, 32'hdead_beef, 1'b1, 1'b1, rc);
      wait_idle("wto_done", 40);
      check("wto_latency", 64'(last_ack_cyc - rc), 64'd16);
      check("wto_valids", {59'h0, ack_valids}, 64'h0);
      slave_defaults();
      rdata_cfg = 32'h0bad_cafe;
      do_read(14'h007, 32'h0bad_cafe, 1'b0, rc);
      wait_idle("after_to_done", 20);
      check("after_to_latency", 64'(last_ack_cyc - rc), 64'd3);

      // Error responses and read timeout
      bresp_cfg = AXI_RESP_SLVERR;
      do_write(14'h011, 32'h5555_aaaa, 1'b1, 1'b1, rc);
      wait_idle("slverr_done", 20);
      rresp_cfg = AXI_RESP_DECERR; rdata_cfg = 32'h1357_9bdf;
      do_read(14'h012, 32'h1357_9bdf, 1'b1, rc);
      wait_idle("decerr_done", 20);
      slave_defaults();
      r_never = 1'b1;
      do_read(14'h013, TIMEOUT_RDATA, 1'b1, rc);
      wait_idle("rto_done", 40);
      check("rto_latency", 64'(last_ack_cyc - rc), 64'd16);
      slave_defaults();

      // Randomised mix with small delays
      for (int i = 0; i < 8; i++) begin
         aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
         ar_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
         r_delay  = $urandom_range(0, 3);
         rr = 2'($urandom_range(0, 3));
         rd_val = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            bresp_cfg = rr;
            do_write(14'($urandom_range(0, 16383)), rd_val, rr[1], 1'b1, rc);
         end else begin
            rresp_cfg = rr; rdata_cfg = rd_val;
            do_read(14'($urandom_range(0, 16383)), rd_val, rr[1], rc);
         end
         wait_idle("rand_done", 40);
      end
      slave_defaults();

      // Reset while waiting in RDATA
      r_delay = 12;
      do_read(14'h044, 32'h0, 1'b0, rc);
      n = 0;
      while (!m_axi_rready && n < 10) begin
         @(negedge up_clk); #2;
         n++;
      end
      check("reach_rdata", {63'h0, m_axi_rready}, 64'h1);
      @(negedge up_clk); #2;
      up_rst = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_outputs", {63'h0, |{up_wack, up_rack, up_rdata, up_busy, up_err, up_ovf,
            m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}}, 64'h0);
      check("midrst_state", {61'h0, dbg_state}, 64'h0);
      @(negedge up_clk); #2;
      up_rst = 1'b0;
      slave_defaults();

      do_write(14'h001, 32'h7777_8888, 1'b0, 1'b1, rc);
      wait_idle("final_done", 20);
      check("final_latency", 64'(last_ack_cyc - rc), 64'd3);

      check("valid_hold", 64'(hold_viol), 64'd0);
      check("bready_early", 64'(bready_early), 64'd0);
      check("rdata_idle_zero", 64'(rdata_nz), 64'd0);
      check("prot_zero", {61'h0, seen_prot}, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
